// File: rtl/can_tx_scheduler_if.sv
// Mailbox and transmitter-side signal bundle for the CAN transmit scheduler.
// The master modport is the host/transmitter side; the slave modport is the scheduler.
interface can_tx_scheduler_if #(
    parameter int NUM_MB = 4
);
    logic [NUM_MB-1:0]    mb_req;
    logic [11*NUM_MB-1:0] mb_id;
    logic [8*NUM_MB-1:0]  mb_data;
    logic [NUM_MB-1:0]    mb_pending;
    logic [NUM_MB-1:0]    mb_done;
    logic [NUM_MB-1:0]    mb_err;
    logic                 tx_start;
    logic [10:0]          tx_id;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 arbitration_lost;
    logic                 bus_idle;
    logic [2:0]           cur_mb;

    modport master (
        output mb_req, mb_id, mb_data, tx_busy, arbitration_lost, bus_idle,
        input  mb_pending, mb_done, mb_err, tx_start, tx_id, tx_data, cur_mb
    );

    modport slave (
        input  mb_req, mb_id, mb_data, tx_busy, arbitration_lost, bus_idle,
        output mb_pending, mb_done, mb_err, tx_start, tx_id, tx_data, cur_mb
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// Shares one CAN transmitter among NUM_MB mailboxes: lowest-ID-first launch,
// re-queue on lost arbitration, drop after RETRY_LIMIT retries or a start timeout.
module can_tx_scheduler #(
    parameter int NUM_MB        = 4,
    parameter int RETRY_LIMIT   = 8,
    parameter int START_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    can_tx_scheduler_if.slave bus
);
    localparam int          IW = $clog2(NUM_MB);
    localparam int          TW = $clog2(START_TIMEOUT + 1);
    localparam logic [7:0]  RL = 8'(RETRY_LIMIT);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SELECT, LAUNCH, ACTIVE} state_t;

    state_t            state_r, state_s;
    logic [NUM_MB-1:0] pending_r, done_r, err_r;
    logic [10:0]       id_r [NUM_MB];
    logic [7:0]        data_r [NUM_MB];
    logic [7:0]        retry_cnt_r [NUM_MB];
    logic [2:0]        cur_r;
    logic [10:0]       tx_id_r;
    logic [7:0]        tx_data_r;
    logic              tx_start_r;
    logic              lost_r;
    logic [TW-1:0]     tmo_r;

    logic [IW-1:0]     cur_idx_s, sel_idx_s;
    logic [10:0]       best_id_s;
    logic              sel_found_s;
    logic              retire_s, ok_s, retry_inc_s, owned_s;

    assign cur_idx_s = cur_r[IW-1:0];
    assign owned_s   = (state_r == LAUNCH) || (state_r == ACTIVE);

    // Winner search: strict less-than keeps the lowest index on equal IDs.
    always_comb begin
        sel_idx_s   = '0;
        best_id_s   = 11'h7FF;
        sel_found_s = 1'b0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pending_r[i] && (!sel_found_s || (id_r[i] < best_id_s))) begin
                sel_found_s = 1'b1;
                best_id_s   = id_r[i];
                sel_idx_s   = IW'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state and retirement decisions.
    always_comb begin
        state_s     = state_r;
        retire_s    = 1'b0;
        ok_s        = 1'b0;
        retry_inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if ((|pending_r) && bus.bus_idle) begin
                    state_s = SELECT;
                end else begin
                    state_s = IDLE;
                end
            end
            SELECT: state_s = LAUNCH;
            LAUNCH: begin
                if (bus.tx_busy) begin
                    state_s = ACTIVE;
                end else if (tmo_r == TMO_LAST) begin
                    state_s  = IDLE;
                    retire_s = 1'b1;
                end else begin
                    state_s = LAUNCH;
                end
            end
            ACTIVE: begin
                if (!bus.tx_busy) begin
                    state_s = IDLE;
                    if (lost_r || bus.arbitration_lost) begin
                        if (retry_cnt_r[cur_idx_s] >= RL) begin
                            retire_s = 1'b1;
                        end else begin
                            retry_inc_s = 1'b1;
                        end
                    end else begin
                        retire_s = 1'b1;
                        ok_s     = 1'b1;
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, mailbox latches, launch registers and completion pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            pending_r  <= '0;
            done_r     <= '0;
            err_r      <= '0;
            cur_r      <= 3'd0;
            tx_id_r    <= 11'd0;
            tx_data_r  <= 8'd0;
            tx_start_r <= 1'b0;
            lost_r     <= 1'b0;
            tmo_r      <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                id_r[i]        <= 11'd0;
                data_r[i]      <= 8'd0;
                retry_cnt_r[i] <= 8'd0;
            end
        end else begin
            state_r    <= state_s;
            done_r     <= '0;
            err_r      <= '0;
            tx_start_r <= (state_s == LAUNCH);
            // The owning mailbox's latch is frozen while the transmitter uses it.
            for (int i = 0; i < NUM_MB; i++) begin
                if (bus.mb_req[i] && !(pending_r[i] && owned_s && (cur_idx_s == IW'(i)))) begin
                    pending_r[i] <= 1'b1;
                    id_r[i]      <= bus.mb_id[11*i +: 11];
                    data_r[i]    <= bus.mb_data[8*i +: 8];
                end
            end
            if (state_r == SELECT) begin
                cur_r     <= 3'(sel_idx_s);
                tx_id_r   <= id_r[sel_idx_s];
                tx_data_r <= data_r[sel_idx_s];
                tmo_r     <= '0;
                lost_r    <= 1'b0;
            end else if (state_r == LAUNCH) begin
                tmo_r <= tmo_r + TW'(1);
            end else if ((state_r == ACTIVE) && bus.arbitration_lost) begin
                lost_r <= 1'b1;
            end else begin
                lost_r <= lost_r;
            end
            if (retry_inc_s && (retry_cnt_r[cur_idx_s] != 8'hFF)) begin
                retry_cnt_r[cur_idx_s] <= retry_cnt_r[cur_idx_s] + 8'd1;
            end
            if (retire_s) begin
                pending_r[cur_idx_s]   <= 1'b0;
                retry_cnt_r[cur_idx_s] <= 8'd0;
                done_r[cur_idx_s]      <= ok_s;
                err_r[cur_idx_s]       <= !ok_s;
            end
        end
    end

    assign bus.mb_pending = pending_r;
    assign bus.mb_done    = done_r;
    assign bus.mb_err     = err_r;
    assign bus.tx_start   = tx_start_r;
    assign bus.tx_id      = tx_id_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.cur_mb     = cur_r;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench: a launch scoreboard drives a simple transmitter model and
// compares each launched frame and its completion pulse against queued expectations.
module tb_can_tx_scheduler;
    localparam int NUM_MB = 4;
    localparam int RETRY_LIMIT = 8;
    localparam int START_TIMEOUT = 16;

    typedef struct {
        int          mb;
        logic [10:0] id;
        logic [7:0]  data;
        bit          lose;
        int          outcome;   // 0 retry, 1 done, 2 err
    } launch_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    launch_t exp_q[$];

    can_tx_scheduler_if #(.NUM_MB(NUM_MB)) bus ();

    can_tx_scheduler #(
        .NUM_MB(NUM_MB), .RETRY_LIMIT(RETRY_LIMIT), .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int mb, logic [10:0] id, logic [7:0] data);
        bus.mb_req[mb] = 1'b1;
        bus.mb_id[11*mb +: 11] = id;
        bus.mb_data[8*mb +: 8] = data;
    endtask

    task automatic issue();
        step();
        bus.mb_req = '0;
    endtask

    task automatic push(int mb, logic [10:0] id, logic [7:0] data, bit lose, int outcome);
        launch_t e;
        e.mb = mb; e.id = id; e.data = data; e.lose = lose; e.outcome = outcome;
        exp_q.push_back(e);
    endtask

    task automatic serve_queue();
        launch_t e;
        logic [3:0] one, exp_done, exp_err;
        int w;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = 0;
            while (bus.tx_start !== 1'b1 && w < 50) begin
                step();
                w++;
            end
            checks++;
            if (bus.tx_start !== 1'b1) begin
                errors++;
                $display("FAIL launch_wait mb=%0d tx_start=%b want 1", e.mb, bus.tx_start);
            end
            checks++;
            if (bus.tx_id !== e.id || bus.tx_data !== e.data || bus.cur_mb !== 3'(e.mb)) begin
                errors++;
                $display("FAIL frame got id=%h data=%h cur=%0d want id=%h data=%h cur=%0d",
                         bus.tx_id, bus.tx_data, bus.cur_mb, e.id, e.data, e.mb);
            end
            bus.tx_busy = 1'b1;
            step();
            checks++;
            if (bus.tx_start !== 1'b0) begin
                errors++;
                $display("FAIL start_drop tx_start=%b want 0", bus.tx_start);
            end
            bus.arbitration_lost = e.lose;
            step();
            bus.arbitration_lost = 1'b0;
            step();
            bus.tx_busy = 1'b0;
            step();
            one = 4'b0001;
            exp_done = (e.outcome == 1) ? (one << e.mb) : 4'b0000;
            exp_err  = (e.outcome == 2) ? (one << e.mb) : 4'b0000;
            checks++;
            if (bus.mb_done !== exp_done || bus.mb_err !== exp_err) begin
                errors++;
                $display("FAIL completion mb=%0d done=%b err=%b want done=%b err=%b",
                         e.mb, bus.mb_done, bus.mb_err, exp_done, exp_err);
            end
            checks++;
            if (bus.mb_pending[e.mb] !== (e.outcome == 0)) begin
                errors++;
                $display("FAIL pending mb=%0d got %b want %b", e.mb, bus.mb_pending[e.mb], e.outcome == 0);
            end
            step();
            checks++;
            if (bus.mb_done !== 4'b0000 || bus.mb_err !== 4'b0000) begin
                errors++;
                $display("FAIL pulse_width done=%b err=%b want 0", bus.mb_done, bus.mb_err);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.mb_pending !== 4'b0 || bus.mb_done !== 4'b0 || bus.mb_err !== 4'b0 ||
            bus.tx_start !== 1'b0 || bus.tx_id !== 11'h0 || bus.tx_data !== 8'h0 || bus.cur_mb !== 3'd0) begin
            errors++;
            $display("FAIL reset_state pend=%b done=%b err=%b start=%b id=%h data=%h cur=%0d want all 0",
                     bus.mb_pending, bus.mb_done, bus.mb_err, bus.tx_start, bus.tx_id, bus.tx_data, bus.cur_mb);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        logic [2:0] seen;
        set_req(2, 11'h123, 8'hA5);
        issue();
        seen[0] = bus.tx_start;
        step();
        seen[1] = bus.tx_start;
        step();
        seen[2] = bus.tx_start;
        checks++;
        if (seen !== 3'b100) begin
            errors++;
            $display("FAIL latency tx_start over 3 cycles=%b want 100", seen);
        end
        push(2, 11'h123, 8'hA5, 1'b0, 1);
        serve_queue();
    endtask

    task automatic test_bus_idle();
        bit started = 1'b0;
        bus.bus_idle = 1'b0;
        set_req(0, 11'h010, 8'h11);
        issue();
        repeat (6) begin
            step();
            if (bus.tx_start === 1'b1) started = 1'b1;
        end
        checks++;
        if (started || bus.mb_pending !== 4'b0001) begin
            errors++;
            $display("FAIL bus_busy_hold started=%b pend=%b want 0 and 0001", started, bus.mb_pending);
        end
        bus.bus_idle = 1'b1;
        push(0, 11'h010, 8'h11, 1'b0, 1);
        serve_queue();
    endtask

    task automatic test_priority();
        set_req(0, 11'h200, 8'h01);
        set_req(1, 11'h100, 8'h02);
        set_req(3, 11'h100, 8'h03);
        issue();
        push(1, 11'h100, 8'h02, 1'b0, 1);
        push(3, 11'h100, 8'h03, 1'b0, 1);
        push(0, 11'h200, 8'h01, 1'b0, 1);
        serve_queue();
    endtask

    task automatic test_retry_limit();
        bit started = 1'b0;
        set_req(0, 11'h050, 8'h77);
        issue();
        for (int i = 0; i < RETRY_LIMIT; i++) push(0, 11'h050, 8'h77, 1'b1, 0);
        push(0, 11'h050, 8'h77, 1'b1, 2);
        serve_queue();
        repeat (8) begin
            step();
            if (bus.tx_start === 1'b1 || bus.mb_done !== 4'b0) started = 1'b1;
        end
        checks++;
        if (started || bus.mb_pending !== 4'b0000) begin
            errors++;
            $display("FAIL retry_retired extra_activity=%b pend=%b want 0 and 0000", started, bus.mb_pending);
        end
    endtask

    task automatic test_start_timeout();
        int w = 0;
        int high = 0;
        set_req(1, 11'h0AA, 8'h55);
        issue();
        while (bus.tx_start !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        while (bus.tx_start === 1'b1 && high < 200) begin
            high++;
            step();
        end
        checks++;
        if (high != START_TIMEOUT || bus.mb_err !== 4'b0010 || bus.mb_done !== 4'b0000) begin
            errors++;
            $display("FAIL start_timeout high=%0d err=%b done=%b want %0d, 0010, 0000",
                     high, bus.mb_err, bus.mb_done, START_TIMEOUT);
        end
        checks++;
        if (bus.mb_pending !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_pending pend=%b want 0000", bus.mb_pending);
        end
        step();
        checks++;
        if (bus.mb_err !== 4'b0000 || bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after err=%b start=%b want 0000 0", bus.mb_err, bus.tx_start);
        end
    endtask

    task automatic test_no_preempt();
        int w = 0;
        set_req(2, 11'h300, 8'hC3);
        issue();
        while (bus.tx_start !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        bus.tx_busy = 1'b1;
        step();
        set_req(0, 11'h001, 8'h99);
        issue();
        step();
        checks++;
        if (bus.tx_id !== 11'h300 || bus.tx_data !== 8'hC3 || bus.tx_start !== 1'b0 || bus.mb_pending !== 4'b0101) begin
            errors++;
            $display("FAIL no_preempt id=%h data=%h start=%b pend=%b want 300 c3 0 0101",
                     bus.tx_id, bus.tx_data, bus.tx_start, bus.mb_pending);
        end
        bus.tx_busy = 1'b0;
        step();
        checks++;
        if (bus.mb_done !== 4'b0100) begin
            errors++;
            $display("FAIL preempt_done done=%b want 0100", bus.mb_done);
        end
        push(0, 11'h001, 8'h99, 1'b0, 1);
        serve_queue();
    endtask

    task automatic test_reset_mid_frame();
        int w = 0;
        bit pulse = 1'b0;
        set_req(3, 11'h2AA, 8'h3C);
        issue();
        while (bus.tx_start !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        bus.tx_busy = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (bus.mb_pending !== 4'b0 || bus.mb_done !== 4'b0 || bus.mb_err !== 4'b0 ||
            bus.tx_start !== 1'b0 || bus.tx_id !== 11'h0 || bus.tx_data !== 8'h0 || bus.cur_mb !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid pend=%b done=%b err=%b start=%b id=%h data=%h cur=%0d want all 0",
                     bus.mb_pending, bus.mb_done, bus.mb_err, bus.tx_start, bus.tx_id, bus.tx_data, bus.cur_mb);
        end
        reset = 1'b1;
        bus.tx_busy = 1'b0;
        repeat (4) begin
            step();
            if (bus.mb_done !== 4'b0 || bus.mb_err !== 4'b0 || bus.tx_start !== 1'b0) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("FAIL reset_abandon activity after reset, want none");
        end
        set_req(1, 11'h0F0, 8'h5A);
        issue();
        push(1, 11'h0F0, 8'h5A, 1'b0, 1);
        serve_queue();
    endtask

    initial begin
        bus.mb_req = '0;
        bus.mb_id = '0;
        bus.mb_data = '0;
        bus.tx_busy = 1'b0;
        bus.arbitration_lost = 1'b0;
        bus.bus_idle = 1'b1;
        test_reset();
        test_single_frame();
        test_bus_idle();
        test_priority();
        test_retry_limit();
        test_start_timeout();
        test_no_preempt();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
